// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour type and bar table
// Contents: 640x480@60 timing, clock/latency constants, rgb12_t, colour bar lookup.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_ACTIVE    = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  localparam int CLK_DIV     = 4;
  localparam int RD_LAT      = 2;
  localparam int SCALE_SHIFT = 1;
  localparam int ADDR_W      = 17;

  // Frame-buffer words per stored row.
  localparam int ROW_WORDS   = H_ACTIVE >> SCALE_SHIFT;
  localparam int BAR_W       = H_ACTIVE / 8;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  // Entry 0 (leftmost bar) sits in the low 12 bits.
  localparam logic [8*12-1:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic rgb12_t bar_colour(input logic [9:0] x);
    int idx;
    idx = int'(x) / BAR_W;
    if (idx > 7) idx = 7;
    return rgb12_t'(BAR_TABLE[idx*12 +: 12]);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-tick divider, h/v raster counters, raw sync and frame_start
// Ports: clk, rst_n (async active-low); pe pixel tick; h_cnt/v_cnt raster position;
//        active visible-region flag; h_sync_raw/v_sync_raw active-low issue-side syncs;
//        line_end/frame_end last pixel of line/frame; frame_start registered pulse at (0,0).
module vga_timing
  import vga_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pe,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       h_sync_raw,
  output logic       v_sync_raw,
  output logic       line_end,
  output logic       frame_end,
  output logic       frame_start
);

  localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    pe        = (div_q == DIV_W'(CLK_DIV - 1));
    div_d     = pe ? '0 : div_q + 1'b1;
    line_end  = (h_q == 10'(H_TOTAL - 1));
    frame_end = line_end && (v_q == 10'(V_TOT - 1));

    h_d = h_q;
    v_d = v_q;
    if (pe) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    frame_start_d = pe && (h_q == '0) && (v_q == '0);
    active        = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACT));
    h_sync_raw    = !((h_q >= 10'(H_ACTIVE + H_FP)) &&
                      (h_q <= 10'(H_ACTIVE + H_FP + H_SYNC - 1)));
    v_sync_raw    = !((v_q >= 10'(V_ACT + V_FRONT)) &&
                      (v_q <= 10'(V_ACT + V_FRONT + V_SW - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - VRAM fetch, pixel doubling, read-latency capture and registered VGA outputs
// Ports: clk, rst_n (async active-low); vram_addr/vram_rd read request, vram_data {R,G,B}
//        returned RD_LAT clks after vram_rd; vga_red/green/blue, vga_h_sync/v_sync (active low),
//        frame_start pulse at (0,0). Optional VGA_TEST_PATTERN_EN adds test_mode (colour bars).
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [11:0]       vram_data,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              vga_h_sync,
  output logic              vga_v_sync,
  output logic              frame_start
);

  logic       pe, active, hs_raw, vs_raw, line_end, frame_end, tm;
  logic [9:0] h_cnt, v_cnt;

  vga_timing #(
    .V_ACT  (V_ACT),
    .V_FRONT(V_FRONT),
    .V_SW   (V_SW),
    .V_BACK (V_BACK)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .pe         (pe),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .h_sync_raw (hs_raw),
    .v_sync_raw (vs_raw),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .frame_start(frame_start)
  );

`ifdef VGA_TEST_PATTERN_EN
  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  rgb12_t            held_q, held_d;
  // Issue stage: attributes of the pixel fetched on the previous tick.
  logic              act_s_q, act_s_d;
  logic              hs_s_q, hs_s_d;
  logic              vs_s_q, vs_s_d;
  rgb12_t            rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
`ifdef VGA_TEST_PATTERN_EN
  logic              tp_s_q, tp_s_d;
  rgb12_t            pat_s_q, pat_s_d;
`endif

  always_comb begin
    row_base_d = row_base_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    // Shift register marks when the word requested RD_LAT clks ago is on vram_data.
    rd_pipe_d  = RD_LAT'({rd_pipe_q, rd_q});
    held_d     = rd_pipe_q[RD_LAT-1] ? rgb12_t'(vram_data) : held_q;
    act_s_d    = act_s_q;
    hs_s_d     = hs_s_q;
    vs_s_d     = vs_s_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
`ifdef VGA_TEST_PATTERN_EN
    tp_s_d     = tp_s_q;
    pat_s_d    = pat_s_q;
`endif

    if (pe) begin
      if (active && !tm) begin
        rd_d   = 1'b1;
        addr_d = row_base_q + ADDR_W'(h_cnt >> SCALE_SHIFT);
      end

      // Row base steps once per replicated group of lines, so no multiply is needed.
      if (frame_end) begin
        row_base_d = '0;
      end else if (line_end && (v_cnt < 10'(V_ACT)) && (&v_cnt[SCALE_SHIFT-1:0])) begin
        row_base_d = row_base_q + ADDR_W'(ROW_WORDS);
      end

      // held_d (not held_q) keeps this correct when capture and tick coincide.
      rgb_d = act_s_q ? held_d : '0;
`ifdef VGA_TEST_PATTERN_EN
      if (tp_s_q) rgb_d = act_s_q ? pat_s_q : '0;
      tp_s_d  = tm;
      pat_s_d = bar_colour(h_cnt);
`endif
      hs_d    = hs_s_q;
      vs_d    = vs_s_q;
      act_s_d = active;
      hs_s_d  = hs_raw;
      vs_s_d  = vs_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      rd_pipe_q  <= '0;
      held_q     <= '0;
      act_s_q    <= 1'b0;
      hs_s_q     <= 1'b1;
      vs_s_q     <= 1'b1;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      tp_s_q     <= 1'b0;
      pat_s_q    <= '0;
`endif
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      rd_pipe_q  <= rd_pipe_d;
      held_q     <= held_d;
      act_s_q    <= act_s_d;
      hs_s_q     <= hs_s_d;
      vs_s_q     <= vs_s_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
`ifdef VGA_TEST_PATTERN_EN
      tp_s_q     <= tp_s_d;
      pat_s_q    <= pat_s_d;
`endif
    end
  end

  assign vram_addr  = addr_q;
  assign vram_rd    = rd_q;
  assign vga_red    = rgb_q.red;
  assign vga_green  = rgb_q.green;
  assign vga_blue   = rgb_q.blue;
  assign vga_h_sync = hs_q;
  assign vga_v_sync = vs_q;

endmodule
